// File: rtl/gsim_host.sv
// Host-side b loader and x collector for the Gauss-Seidel solver core.
// Each solve runs RST -> GAP -> LOAD(N words) -> WAIT -> CAPT(N words); the solver's reset is owned here.
module gsim_host #(
   parameter int N       = 16,
   parameter int BW      = 16,
   parameter int XW      = 32,
   parameter int TIMEOUT = 4095
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   wr_en,
   input  logic [$clog2(N)-1:0]   wr_addr,
   input  logic [BW-1:0]          wr_data,
   input  logic                   start,
   input  logic [$clog2(N)-1:0]   rd_addr,
   output logic [XW-1:0]          rd_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   gs_rst,
   output logic                   gs_in_en,
   output logic [BW-1:0]          gs_b,
   input  logic                   gs_out_valid,
   input  logic [XW-1:0]          gs_x
);
   localparam int          AW      = $clog2(N);
   localparam logic [AW-1:0] K_LAST = AW'(N - 1);
   localparam logic [11:0] TMO_LIM = 12'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP, S_LOAD, S_WAIT, S_CAPT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   k_q, k_d, k_inc;
   logic [11:0]     tmo_q, tmo_d;
   logic            gs_rst_q, gs_rst_d;
   logic            gs_in_en_q, gs_in_en_d;
   logic [BW-1:0]   gs_b_q, gs_b_d;
   logic            busy_q;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            x_we;
   logic [AW-1:0]   x_wa;
   logic [BW-1:0]   b_q [N];
   logic [XW-1:0]   x_q [N];

   assign k_inc = k_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      tmo_d      = tmo_q;
      gs_rst_d   = 1'b0;
      gs_in_en_d = 1'b0;
      gs_b_d     = '0;
      done_d     = done_q;
      err_d      = err_q;
      x_we       = 1'b0;
      x_wa       = k_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RST;
               gs_rst_d = 1'b1;
               done_d   = 1'b0;
               err_d    = 1'b0;
               k_d      = '0;
            end
         end
         S_RST: state_d = S_GAP;
         S_GAP: begin
            state_d    = S_LOAD;
            gs_in_en_d = 1'b1;
            gs_b_d     = b_q[0];
         end
         // k_q is the index currently on gs_b; the next word is fetched one cycle ahead
         S_LOAD: begin
            if (k_q == K_LAST) begin
               state_d = S_WAIT;
               k_d     = '0;
               tmo_d   = '0;
            end else begin
               k_d        = k_inc;
               gs_in_en_d = 1'b1;
               gs_b_d     = b_q[k_inc];
            end
         end
         S_WAIT: begin
            if (gs_out_valid) begin
               x_we    = 1'b1;
               x_wa    = '0;
               state_d = S_CAPT;
               k_d     = AW'(1);
            end else begin
               if (tmo_q != 12'hFFF) tmo_d = tmo_q + 12'd1;
               if (tmo_d == TMO_LIM) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_CAPT: begin
            if (gs_out_valid) begin
               x_we = 1'b1;
               k_d  = k_inc;
               if (k_q == K_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               k_d     = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         tmo_q      <= '0;
         gs_rst_q   <= 1'b1;
         gs_in_en_q <= 1'b0;
         gs_b_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         tmo_q      <= tmo_d;
         gs_rst_q   <= gs_rst_d;
         gs_in_en_q <= gs_in_en_d;
         gs_b_q     <= gs_b_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Host writes land only while idle so a solve always streams a stable vector
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) b_q[i] <= '0;
      end else if (wr_en && (state_q == S_IDLE)) begin
         b_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) x_q[i] <= '0;
      end else if (x_we) begin
         x_q[x_wa] <= gs_x;
      end
   end

   assign rd_data  = x_q[rd_addr];
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign gs_rst   = gs_rst_q;
   assign gs_in_en = gs_in_en_q;
   assign gs_b     = gs_b_q;
endmodule
